// File: rtl/mpc_types_pkg.sv
// Shared types for the MPC cache pipeline: geometry, cache op codes and the
// issue-queue entry layout used by the issue unit.
package mpc_types;

  typedef struct packed {
    logic [7:0] rob_size;
    logic [3:0] crdt_init;
  } mpc_cfg_t;

  localparam mpc_cfg_t MPC_CFG = '{rob_size: 8'd16, crdt_init: 4'd4};

  localparam int SET_W     = 3;
  localparam int WAY_W     = 2;
  localparam int NLINE_W   = WAY_W + SET_W;
  localparam int OFF_W     = 1;
  localparam int WBUF_W    = 7;
  localparam int ROB_SIZE  = int'(MPC_CFG.rob_size);
  localparam int ROB_W     = $clog2(ROB_SIZE);
  localparam int DATA_W    = 128;
  localparam int NCH       = 3;
  localparam int CRDT_INIT = int'(MPC_CFG.crdt_init);
  localparam int CRDT_W    = $clog2(CRDT_INIT + 1);

  typedef enum logic [2:0] {
    CACHE_OP_LOAD  = 3'd0,
    CACHE_OP_STORE = 3'd1,
    CACHE_OP_WAE   = 3'd2,
    CACHE_OP_FLUSH = 3'd3,
    CACHE_OP_INV   = 3'd4
  } cache_op_e;

  typedef struct packed {
    logic               valid;
    logic [NCH-1:0]     chan;
    logic [2:0]         op;
    logic [NLINE_W-1:0] id;
    logic [OFF_W-1:0]   off;
    logic [WBUF_W-1:0]  wbuf;
    logic               owner;
    logic               waiting;
    logic [SET_W-1:0]   set_idx;
    logic [WAY_W-1:0]   way_idx;
    logic [DATA_W-1:0]  data;
  } isu_entry_t;

  // Channels are one-hot; returns the bit position of the set bit.
  function automatic logic [1:0] chan_index(input logic [NCH-1:0] onehot);
    chan_index = 2'd0;
    for (int c = 0; c < NCH; c++) begin
      if (onehot[c]) chan_index = 2'(c);
    end
  endfunction

endpackage

// File: rtl/mpc_isu_age_pick.sv
// Circular priority picker: returns the first set request found scanning
// upward from the start pointer, wrapping around the queue.
module mpc_isu_age_pick
  import mpc_types::*;
(
  input  logic [ROB_SIZE-1:0] req,
  input  logic [ROB_W-1:0]    start,
  output logic [ROB_W-1:0]    grant,
  output logic                found
);

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (!found && req[start + ROB_W'(i)]) begin
        found = 1'b1;
        grant = start + ROB_W'(i);
      end
    end
  end

endmodule

// File: rtl/mpc_isu.sv
// MPC issue unit: queues HTU requests, parks misses until refill, and
// dispatches ready entries oldest-first to d_rc under per-channel credits.
module mpc_isu
  import mpc_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                u_htu_valid,
  output logic                u_htu_ready,
  input  logic [NCH-1:0]      u_htu_channel_1hot_id,
  input  logic [2:0]          u_htu_op,
  input  logic [NLINE_W-1:0]  u_htu_id,
  input  logic [OFF_W-1:0]    u_htu_offset,
  input  logic [WBUF_W-1:0]   u_htu_wbuf_id,
  input  logic                u_htu_refill_valid,
  input  logic [SET_W-1:0]    u_htu_refill_set,
  input  logic [WAY_W-1:0]    u_htu_refill_way,
  input  logic                memctl_refill_valid,
  output logic                memctl_refill_ready,
  input  logic [NLINE_W-1:0]  memctl_refill_id,
  input  logic [DATA_W-1:0]   memctl_refill_data,
  input  logic [NCH-1:0]      u_xbar_crdt_rtn,
  output logic                d_rc_valid,
  input  logic                d_rc_ready,
  output logic [NCH-1:0]      d_rc_channel_1hot_id,
  output logic [ROB_W-1:0]    d_rc_rob_id,
  output logic [2:0]          d_rc_op,
  output logic [SET_W-1:0]    d_rc_set,
  output logic [WAY_W-1:0]    d_rc_way,
  output logic [WBUF_W-1:0]   d_rc_wbuf_id,
  output logic [DATA_W-1:0]   d_rc_refill_data,
  output logic                u_htu_crdt_valid,
  output logic [NLINE_W-1:0]  u_htu_crdt_way_set
);

  isu_entry_t          entry_q [ROB_SIZE];
  logic [ROB_W-1:0]    tail_q;
  logic [CRDT_W-1:0]   credit_q [NCH];
  logic                running_q;
  logic                hold_q;
  logic [ROB_W-1:0]    hold_idx_q;
  logic                crdt_valid_q;
  logic [NLINE_W-1:0]  crdt_id_q;

  logic [ROB_SIZE-1:0] cand;
  logic [ROB_SIZE-1:0] dep_hit;
  logic [ROB_W-1:0]    pick_idx;
  logic                pick_found;
  logic [ROB_W-1:0]    sel_idx;
  isu_entry_t          sel;
  isu_entry_t          new_entry;
  logic                alloc_fire;
  logic                refill_fire;
  logic                disp_fire;
  logic [NCH-1:0]      disp_ch;
  logic                unused_off;

  assign u_htu_ready         = running_q & ~entry_q[tail_q].valid;
  assign memctl_refill_ready = running_q;
  assign alloc_fire          = u_htu_valid & u_htu_ready;
  assign refill_fire         = memctl_refill_valid & memctl_refill_ready;
  assign u_htu_crdt_valid    = crdt_valid_q;
  assign u_htu_crdt_way_set  = crdt_id_q;

  always_comb begin
    cand       = '0;
    dep_hit    = '0;
    unused_off = 1'b0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      cand[i]    = entry_q[i].valid & ~entry_q[i].waiting &
                   (credit_q[chan_index(entry_q[i].chan)] != '0);
      dep_hit[i] = entry_q[i].valid & entry_q[i].owner & entry_q[i].waiting &
                   (entry_q[i].id == u_htu_id);
      unused_off = unused_off ^ entry_q[i].off[0];
    end
  end

  mpc_isu_age_pick u_pick (
    .req   (cand),
    .start (tail_q),
    .grant (pick_idx),
    .found (pick_found)
  );

  // A stalled dispatch is pinned so d_rc_* cannot change under backpressure.
  assign sel_idx    = hold_q ? hold_idx_q : pick_idx;
  assign sel        = entry_q[sel_idx];
  assign d_rc_valid = hold_q | pick_found;
  assign disp_fire  = d_rc_valid & d_rc_ready;
  assign disp_ch    = d_rc_channel_1hot_id & {NCH{disp_fire}};

  always_comb begin
    d_rc_channel_1hot_id = '0;
    d_rc_rob_id          = '0;
    d_rc_op              = '0;
    d_rc_set             = '0;
    d_rc_way             = '0;
    d_rc_wbuf_id         = '0;
    d_rc_refill_data     = '0;
    if (d_rc_valid) begin
      d_rc_channel_1hot_id = sel.chan;
      d_rc_rob_id          = sel_idx;
      d_rc_op              = sel.op;
      d_rc_set             = sel.set_idx;
      d_rc_way             = sel.way_idx;
      d_rc_wbuf_id         = sel.wbuf;
      d_rc_refill_data     = sel.owner ? sel.data : '0;
    end
  end

  // A dependent arriving alongside its line's refill must not wait for it again.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.chan    = u_htu_channel_1hot_id;
    new_entry.op      = u_htu_op;
    new_entry.id      = u_htu_id;
    new_entry.off     = u_htu_offset;
    new_entry.wbuf    = u_htu_wbuf_id;
    new_entry.owner   = u_htu_refill_valid;
    new_entry.waiting = u_htu_refill_valid |
                        ((|dep_hit) & ~(refill_fire & (memctl_refill_id == u_htu_id)));
    new_entry.set_idx = u_htu_refill_valid ? u_htu_refill_set : u_htu_id[SET_W-1:0];
    new_entry.way_idx = u_htu_refill_valid ? u_htu_refill_way : u_htu_id[NLINE_W-1:SET_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) entry_q[i].valid <= 1'b0;
      for (int c = 0; c < NCH; c++) credit_q[c] <= CRDT_W'(CRDT_INIT);
      tail_q       <= '0;
      running_q    <= 1'b0;
      hold_q       <= 1'b0;
      hold_idx_q   <= '0;
      crdt_valid_q <= 1'b0;
      crdt_id_q    <= '0;
    end else begin
      running_q <= 1'b1;
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (refill_fire && entry_q[i].valid && entry_q[i].waiting &&
            entry_q[i].id == memctl_refill_id) begin
          entry_q[i].waiting <= 1'b0;
          if (entry_q[i].owner) entry_q[i].data <= memctl_refill_data;
        end
        if (disp_fire && sel_idx == ROB_W'(i)) entry_q[i].valid <= 1'b0;
      end
      if (alloc_fire) begin
        entry_q[tail_q] <= new_entry;
        tail_q          <= tail_q + ROB_W'(1);
      end
      for (int c = 0; c < NCH; c++) begin
        if (u_xbar_crdt_rtn[c] && !disp_ch[c] && credit_q[c] != CRDT_W'(CRDT_INIT))
          credit_q[c] <= credit_q[c] + CRDT_W'(1);
        else if (disp_ch[c] && !u_xbar_crdt_rtn[c])
          credit_q[c] <= credit_q[c] - CRDT_W'(1);
      end
      hold_q       <= d_rc_valid & ~d_rc_ready;
      hold_idx_q   <= sel_idx;
      crdt_valid_q <= refill_fire;
      crdt_id_q    <= memctl_refill_id;
    end
  end

endmodule

// File: tb/tb_mpc_isu.sv
// Self-checking bench for mpc_isu: table-driven hit vectors, directed
// miss/dependency/credit/reset sequences, and a randomized run against an age-ordered model.
module tb_mpc_isu;
  import mpc_types::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         u_htu_valid, u_htu_ready;
  logic [2:0]   u_htu_channel_1hot_id, u_htu_op;
  logic [4:0]   u_htu_id;
  logic [0:0]   u_htu_offset;
  logic [6:0]   u_htu_wbuf_id;
  logic         u_htu_refill_valid;
  logic [2:0]   u_htu_refill_set;
  logic [1:0]   u_htu_refill_way;
  logic         memctl_refill_valid, memctl_refill_ready;
  logic [4:0]   memctl_refill_id;
  logic [127:0] memctl_refill_data;
  logic [2:0]   u_xbar_crdt_rtn;
  logic         d_rc_valid, d_rc_ready;
  logic [2:0]   d_rc_channel_1hot_id, d_rc_op, d_rc_set;
  logic [3:0]   d_rc_rob_id;
  logic [1:0]   d_rc_way;
  logic [6:0]   d_rc_wbuf_id;
  logic [127:0] d_rc_refill_data;
  logic         u_htu_crdt_valid;
  logic [4:0]   u_htu_crdt_way_set;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mpc_isu dut (
    .clk(clk), .rst(rst),
    .u_htu_valid(u_htu_valid), .u_htu_ready(u_htu_ready),
    .u_htu_channel_1hot_id(u_htu_channel_1hot_id), .u_htu_op(u_htu_op),
    .u_htu_id(u_htu_id), .u_htu_offset(u_htu_offset), .u_htu_wbuf_id(u_htu_wbuf_id),
    .u_htu_refill_valid(u_htu_refill_valid), .u_htu_refill_set(u_htu_refill_set),
    .u_htu_refill_way(u_htu_refill_way),
    .memctl_refill_valid(memctl_refill_valid), .memctl_refill_ready(memctl_refill_ready),
    .memctl_refill_id(memctl_refill_id), .memctl_refill_data(memctl_refill_data),
    .u_xbar_crdt_rtn(u_xbar_crdt_rtn),
    .d_rc_valid(d_rc_valid), .d_rc_ready(d_rc_ready),
    .d_rc_channel_1hot_id(d_rc_channel_1hot_id), .d_rc_rob_id(d_rc_rob_id),
    .d_rc_op(d_rc_op), .d_rc_set(d_rc_set), .d_rc_way(d_rc_way),
    .d_rc_wbuf_id(d_rc_wbuf_id), .d_rc_refill_data(d_rc_refill_data),
    .u_htu_crdt_valid(u_htu_crdt_valid), .u_htu_crdt_way_set(u_htu_crdt_way_set)
  );

  typedef struct {
    logic [2:0] chan;
    logic [2:0] op;
    logic [4:0] id;
    logic       off;
    logic [6:0] wbuf;
    logic [3:0] rob;
    logic [2:0] set_idx;
    logic [1:0] way_idx;
  } hit_vec_t;

  typedef struct {
    int           slot;
    logic [2:0]   chan;
    logic [2:0]   op;
    logic [4:0]   id;
    logic [6:0]   wbuf;
    logic         owner;
    logic         waiting;
    logic [2:0]   set_idx;
    logic [1:0]   way_idx;
    logic [127:0] data;
  } m_entry_t;

  m_entry_t   mq[$];
  int         m_tail;
  int         m_cred[3];
  int         m_held;
  logic       m_pulse;
  logic [4:0] m_pulse_id;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_view(input logic v, input logic [3:0] rob, input logic [2:0] ch,
                                           input logic [2:0] op, input logic [2:0] st, input logic [1:0] wy,
                                           input logic [6:0] wb, input logic [127:0] dt);
    return 256'({v, rob, ch, op, st, wy, wb, dt});
  endfunction

  function automatic logic [255:0] dut_view();
    return mk_view(d_rc_valid, d_rc_rob_id, d_rc_channel_1hot_id, d_rc_op, d_rc_set,
                   d_rc_way, d_rc_wbuf_id, d_rc_refill_data);
  endfunction

  task automatic idle_inputs();
    u_htu_valid = 0; u_htu_channel_1hot_id = 0; u_htu_op = 0; u_htu_id = 0;
    u_htu_offset = 0; u_htu_wbuf_id = 0; u_htu_refill_valid = 0;
    u_htu_refill_set = 0; u_htu_refill_way = 0;
    memctl_refill_valid = 0; memctl_refill_id = 0; memctl_refill_data = 0;
    u_xbar_crdt_rtn = 0; d_rc_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic apply_stimulus(input logic [2:0] ch, input logic [2:0] op, input logic [4:0] id,
                                input logic off, input logic [6:0] wbuf, input logic miss,
                                input logic [2:0] rset, input logic [1:0] rway);
    u_htu_valid = 1; u_htu_channel_1hot_id = ch; u_htu_op = op; u_htu_id = id;
    u_htu_offset = off; u_htu_wbuf_id = wbuf; u_htu_refill_valid = miss;
    u_htu_refill_set = rset; u_htu_refill_way = rway;
    #1;
    check_output("alloc_ready", 256'(u_htu_ready), 256'(1));
    tick();
    u_htu_valid = 0; u_htu_refill_valid = 0;
  endtask

  task automatic refill(input logic [4:0] id, input logic [127:0] data);
    memctl_refill_valid = 1; memctl_refill_id = id; memctl_refill_data = data;
    check_output("refill_ready", 256'(memctl_refill_ready), 256'(1));
    tick();
    memctl_refill_valid = 0;
  endtask

  function automatic int m_ch(input logic [2:0] oh);
    for (int c = 0; c < 3; c++) if (oh[c]) return c;
    return 0;
  endfunction

  function automatic int m_pick();
    if (m_held >= 0) begin
      foreach (mq[i]) if (mq[i].slot == m_held) return i;
      return -1;
    end
    foreach (mq[i]) if (!mq[i].waiting && m_cred[m_ch(mq[i].chan)] > 0) return i;
    return -1;
  endfunction

  function automatic bit m_slot_busy(input int s);
    foreach (mq[i]) if (mq[i].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_random(input int cycles);
    mq.delete(); m_tail = 0; m_held = -1; m_pulse = 0; m_pulse_id = 0;
    for (int c = 0; c < 3; c++) m_cred[c] = 4;
    idle_inputs();
    do_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      int p, rc;
      bit disp, dep, alloc, exp_ready;
      logic [4:0] owner_ids[$];
      u_htu_valid = ($urandom % 3) != 0;
      u_htu_channel_1hot_id = 3'b001 << ($urandom % 3);
      u_htu_op = 3'($urandom_range(0, 4));
      u_htu_id = {2'($urandom), 1'b0, 2'($urandom)};
      u_htu_offset = 1'($urandom);
      u_htu_wbuf_id = 7'($urandom);
      u_htu_refill_valid = ($urandom % 3) == 0;
      u_htu_refill_set = 3'($urandom);
      u_htu_refill_way = 2'($urandom);
      foreach (mq[i]) if (mq[i].owner && mq[i].waiting) owner_ids.push_back(mq[i].id);
      memctl_refill_valid = ($urandom % 4) == 0;
      if (owner_ids.size() > 0 && ($urandom % 4) != 0)
        memctl_refill_id = owner_ids[$urandom % owner_ids.size()];
      else
        memctl_refill_id = 5'($urandom);
      if (u_htu_valid && memctl_refill_id == u_htu_id) memctl_refill_valid = 0;
      memctl_refill_data = {$urandom, $urandom, $urandom, $urandom};
      d_rc_ready = ($urandom % 4) != 0;
      u_xbar_crdt_rtn = 3'($urandom) & 3'($urandom);
      #1;
      exp_ready = !m_slot_busy(m_tail);
      check_output("rnd_htu_ready", 256'(u_htu_ready), 256'(exp_ready));
      check_output("rnd_crdt_valid", 256'(u_htu_crdt_valid), 256'(m_pulse));
      if (m_pulse) check_output("rnd_crdt_way_set", 256'(u_htu_crdt_way_set), 256'(m_pulse_id));
      p = m_pick();
      if (p >= 0)
        check_output("rnd_dispatch", dut_view(),
                     mk_view(1'b1, 4'(mq[p].slot), mq[p].chan, mq[p].op, mq[p].set_idx,
                             mq[p].way_idx, mq[p].wbuf, mq[p].owner ? mq[p].data : 128'd0));
      else
        check_output("rnd_dispatch", dut_view(), 256'd0);

      disp  = (p >= 0) && d_rc_ready;
      alloc = u_htu_valid && exp_ready;
      dep   = 0;
      foreach (mq[i]) if (mq[i].owner && mq[i].waiting && mq[i].id == u_htu_id) dep = 1;
      for (int c = 0; c < 3; c++) begin
        rc = m_cred[c] - ((disp && mq[p].chan[c]) ? 1 : 0) + (u_xbar_crdt_rtn[c] ? 1 : 0);
        m_cred[c] = (rc > 4) ? 4 : rc;
      end
      m_held = (p >= 0 && !d_rc_ready) ? mq[p].slot : -1;
      if (disp) mq.delete(p);
      if (memctl_refill_valid) begin
        foreach (mq[i]) if (mq[i].waiting && mq[i].id == memctl_refill_id) begin
          mq[i].waiting = 0;
          if (mq[i].owner) mq[i].data = memctl_refill_data;
        end
      end
      m_pulse = memctl_refill_valid;
      m_pulse_id = memctl_refill_id;
      if (alloc) begin
        m_entry_t e;
        e.slot = m_tail; e.chan = u_htu_channel_1hot_id; e.op = u_htu_op; e.id = u_htu_id;
        e.wbuf = u_htu_wbuf_id; e.owner = u_htu_refill_valid;
        e.waiting = u_htu_refill_valid || dep;
        e.set_idx = u_htu_refill_valid ? u_htu_refill_set : u_htu_id[2:0];
        e.way_idx = u_htu_refill_valid ? u_htu_refill_way : u_htu_id[4:3];
        e.data = '0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % 16;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    hit_vec_t vecs[5];
    vecs[0] = '{3'b001, CACHE_OP_LOAD,  5'b01_111, 1'b1, 7'd9,   4'd0, 3'd7, 2'd1};
    vecs[1] = '{3'b010, CACHE_OP_STORE, 5'b10_000, 1'b0, 7'd33,  4'd1, 3'd0, 2'd2};
    vecs[2] = '{3'b100, CACHE_OP_WAE,   5'b11_101, 1'b1, 7'd127, 4'd2, 3'd5, 2'd3};
    vecs[3] = '{3'b001, CACHE_OP_STORE, 5'b00_010, 1'b0, 7'd0,   4'd3, 3'd2, 2'd0};
    vecs[4] = '{3'b010, CACHE_OP_LOAD,  5'b11_111, 1'b1, 7'd64,  4'd4, 3'd7, 2'd3};

    idle_inputs();
    rst = 1;
    tick();
    tick();
    check_output("in_reset_outputs", 256'({u_htu_ready, memctl_refill_ready, u_htu_crdt_valid}), 256'(0));
    rst = 0;
    tick();
    check_output("post_reset_ready", 256'({u_htu_ready, memctl_refill_ready}), 256'(2'b11));
    check_output("post_reset_dispatch", dut_view(), 256'd0);
    check_output("post_reset_crdt", 256'(u_htu_crdt_valid), 256'(0));

    // hits: each dispatches the cycle after allocation
    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].chan, vecs[v].op, vecs[v].id, vecs[v].off, vecs[v].wbuf, 1'b0, 3'd0, 2'd0);
      check_output("hit_dispatch", dut_view(),
                   mk_view(1'b1, vecs[v].rob, vecs[v].chan, vecs[v].op, vecs[v].set_idx,
                           vecs[v].way_idx, vecs[v].wbuf, 128'd0));
      d_rc_ready = 1; u_xbar_crdt_rtn = vecs[v].chan;
      tick();
      d_rc_ready = 0; u_xbar_crdt_rtn = 0;
      check_output("hit_drained", 256'(d_rc_valid), 256'(0));
    end

    // miss held until refill, with completion pulse
    do_reset();
    apply_stimulus(3'b100, CACHE_OP_STORE, 5'b10_110, 1'b0, 7'd8, 1'b1, 3'd6, 2'd2);
    tick(); tick();
    check_output("miss_held", 256'(d_rc_valid), 256'(0));
    refill(5'b10_110, 128'hffffeeeeffffeeee);
    check_output("miss_crdt_pulse", 256'({u_htu_crdt_valid, u_htu_crdt_way_set}), 256'({1'b1, 5'b10_110}));
    check_output("miss_dispatch", dut_view(),
                 mk_view(1'b1, 4'd0, 3'b100, CACHE_OP_STORE, 3'd6, 2'd2, 7'd8, 128'hffffeeeeffffeeee));
    d_rc_ready = 1;
    tick();
    d_rc_ready = 0;
    check_output("miss_pulse_single", 256'(u_htu_crdt_valid), 256'(0));
    check_output("miss_drained", 256'(d_rc_valid), 256'(0));

    // out-of-order refill completion
    do_reset();
    apply_stimulus(3'b100, CACHE_OP_WAE,   5'b11_101, 1'b0, 7'd1, 1'b1, 3'd5, 2'd3);
    apply_stimulus(3'b100, CACHE_OP_STORE, 5'b10_110, 1'b0, 7'd2, 1'b1, 3'd6, 2'd2);
    refill(5'b10_110, 128'h1234);
    check_output("ooo_first", dut_view(),
                 mk_view(1'b1, 4'd1, 3'b100, CACHE_OP_STORE, 3'd6, 2'd2, 7'd2, 128'h1234));
    d_rc_ready = 1;
    tick();
    d_rc_ready = 0;
    refill(5'b11_101, 128'h5678);
    check_output("ooo_second", dut_view(),
                 mk_view(1'b1, 4'd0, 3'b100, CACHE_OP_WAE, 3'd5, 2'd3, 7'd1, 128'h5678));
    d_rc_ready = 1;
    tick();
    d_rc_ready = 0;

    // hit-under-miss dependent waits for the owner's refill
    do_reset();
    apply_stimulus(3'b001, CACHE_OP_LOAD, 5'b01_011, 1'b0, 7'd10, 1'b1, 3'd3, 2'd1);
    apply_stimulus(3'b001, CACHE_OP_LOAD, 5'b01_011, 1'b0, 7'd11, 1'b0, 3'd0, 2'd0);
    tick();
    check_output("dep_held", 256'(d_rc_valid), 256'(0));
    refill(5'b01_011, 128'haaaabbbbccccdddd);
    check_output("dep_owner", dut_view(),
                 mk_view(1'b1, 4'd0, 3'b001, CACHE_OP_LOAD, 3'd3, 2'd1, 7'd10, 128'haaaabbbbccccdddd));
    d_rc_ready = 1;
    tick();
    check_output("dep_second", dut_view(),
                 mk_view(1'b1, 4'd1, 3'b001, CACHE_OP_LOAD, 3'd3, 2'd1, 7'd11, 128'd0));
    tick();
    d_rc_ready = 0;

    // backpressure hold, then credit exhaustion on channel 0
    do_reset();
    for (int k = 0; k < 5; k++)
      apply_stimulus(3'b001, CACHE_OP_LOAD, 5'b00_001, 1'b0, 7'(20 + k), 1'b0, 3'd0, 2'd0);
    tick(); tick();
    check_output("bp_stable", dut_view(),
                 mk_view(1'b1, 4'd0, 3'b001, CACHE_OP_LOAD, 3'd1, 2'd0, 7'd20, 128'd0));
    d_rc_ready = 1;
    for (int k = 0; k < 4; k++) begin
      check_output("credit_dispatch", 256'({d_rc_valid, d_rc_wbuf_id}), 256'({1'b1, 7'(20 + k)}));
      tick();
    end
    check_output("credit_stall", 256'(d_rc_valid), 256'(0));
    tick();
    check_output("credit_stall2", 256'(d_rc_valid), 256'(0));
    u_xbar_crdt_rtn = 3'b001;
    tick();
    u_xbar_crdt_rtn = 0;
    check_output("credit_release", 256'({d_rc_valid, d_rc_wbuf_id}), 256'({1'b1, 7'd24}));
    tick();
    d_rc_ready = 0;

    // full queue, then mid-run reset restores entries and credits
    for (int k = 0; k < 16; k++)
      apply_stimulus(3'b010, CACHE_OP_LOAD, 5'(k), 1'b0, 7'(k), 1'b1, 3'(k), 2'(k));
    check_output("full_not_ready", 256'(u_htu_ready), 256'(0));
    check_output("full_no_dispatch", 256'(d_rc_valid), 256'(0));
    rst = 1;
    tick();
    check_output("reset_outputs",
                 256'({u_htu_ready, memctl_refill_ready, u_htu_crdt_valid, u_htu_crdt_way_set}), 256'(0));
    check_output("reset_dispatch", dut_view(), 256'd0);
    rst = 0;
    tick();
    check_output("reset_ready", 256'({u_htu_ready, memctl_refill_ready}), 256'(2'b11));
    for (int k = 0; k < 5; k++)
      apply_stimulus(3'b001, CACHE_OP_STORE, 5'b00_100, 1'b0, 7'(40 + k), 1'b0, 3'd0, 2'd0);
    d_rc_ready = 1;
    for (int k = 0; k < 4; k++) begin
      check_output("reset_credit_dispatch", 256'({d_rc_valid, d_rc_rob_id, d_rc_wbuf_id}),
                   256'({1'b1, 4'(k), 7'(40 + k)}));
      tick();
    end
    check_output("reset_credit_stall", 256'(d_rc_valid), 256'(0));
    d_rc_ready = 0;

    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
